// File: rtl/cpu_defs.sv
// Shared definitions for the instruction fetch queue: entry widths, field offsets, entry layout.
package cpu_defs;

  localparam int unsigned IQ_ADDR_WIDTH      = 17;
  localparam int unsigned IQ_INST_WIDTH      = 32;
  localparam int unsigned INST_Q_ENTRY_WIDTH = IQ_ADDR_WIDTH + IQ_INST_WIDTH;
  localparam int unsigned ENTRY_INST_LSB     = 0;
  localparam int unsigned ENTRY_PC_LSB       = IQ_INST_WIDTH;

  typedef struct packed {
    logic [IQ_ADDR_WIDTH-1:0] pc;
    logic [IQ_INST_WIDTH-1:0] inst;
  } inst_q_entry_t;

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage for the fetch queue: one synchronous write port, DEQ_WIDTH async reads at head+i.
module inst_queue_ram
  import cpu_defs::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned EW        = INST_Q_ENTRY_WIDTH,
  parameter int unsigned DEQ_WIDTH = 2,
  parameter int unsigned PW        = $clog2(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [PW-1:0]           i_waddr,
  input  logic [EW-1:0]           i_wdata,
  input  logic [PW-1:0]           i_head,
  output logic [DEQ_WIDTH*EW-1:0] o_rdata
);

  logic [EW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // PW-bit address arithmetic wraps DEPTH-1 -> 0 for free.
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < int'(DEQ_WIDTH); i++) begin
      o_rdata[i*EW +: EW] = r_mem[i_head + PW'(i)];
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// In-order {pc, inst} queue: one enqueue per cycle, up to DEQ_WIDTH oldest entries dequeued.
// Optional same-cycle bypass of an empty queue is enabled by defining INST_QUEUE_BYPASS_EN.
module inst_fetch_queue
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_WIDTH = IQ_ADDR_WIDTH,
  parameter int unsigned INST_WIDTH = IQ_INST_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DEQ_WIDTH  = 2
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst,
  input  logic                                           i_rdy,
  input  logic                                           i_flush,
  input  logic                                           i_enq_valid,
  input  logic [ADDR_WIDTH+INST_WIDTH-1:0]               i_enq_entry,
  output logic                                           o_enq_ready,
  output logic [DEQ_WIDTH-1:0]                           o_deq_valid,
  output logic [DEQ_WIDTH*(ADDR_WIDTH+INST_WIDTH)-1:0]   o_deq_entry,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0]                 i_deq_take,
  output logic [$clog2(DEPTH):0]                         o_count
);

  localparam int unsigned EW = ADDR_WIDTH + INST_WIDTH;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]           r_head, r_tail, w_head_next, w_tail_next;
  logic [CW-1:0]           r_count, w_count_next;
  logic [CW-1:0]           w_avail, w_take, w_take_mem;
  logic                    w_enq_fire, w_bypass, w_bypass_taken, w_wr_en;
  logic [DEQ_WIDTH*EW-1:0] w_ram_rdata;

  always_comb begin
    o_enq_ready = i_rdy && (r_count < CW'(DEPTH));
    w_enq_fire  = i_enq_valid && o_enq_ready;
`ifdef INST_QUEUE_BYPASS_EN
    w_bypass = i_rdy && !i_flush && i_enq_valid && (r_count == '0);
`else
    w_bypass = 1'b0;
`endif

    for (int i = 0; i < int'(DEQ_WIDTH); i++) begin
      o_deq_valid[i] = i_rdy && (r_count > CW'(i));
    end
    o_deq_entry = w_ram_rdata;
    if (w_bypass) begin
      o_deq_valid[0]      = 1'b1;
      o_deq_entry[EW-1:0] = i_enq_entry;
    end

    // Number of valid lanes; an oversized take is clamped to it.
    if (!i_rdy) begin
      w_avail = '0;
    end else if (r_count > CW'(DEQ_WIDTH)) begin
      w_avail = CW'(DEQ_WIDTH);
    end else begin
      w_avail = r_count;
    end
    if (w_bypass) begin
      w_avail = CW'(1);
    end
    w_take = (CW'(i_deq_take) > w_avail) ? w_avail : CW'(i_deq_take);

    // A bypassed entry consumed this cycle never touches storage.
    w_bypass_taken = w_bypass && (w_take != '0);
    w_take_mem     = w_bypass_taken ? '0 : w_take;
    w_wr_en        = w_enq_fire && !w_bypass_taken && !i_flush;

    w_head_next  = r_head;
    w_tail_next  = r_tail;
    w_count_next = r_count;
    if (i_rdy) begin
      if (i_flush) begin
        w_head_next  = '0;
        w_tail_next  = '0;
        w_count_next = '0;
      end else begin
        w_head_next  = r_head + PW'(w_take_mem);
        w_tail_next  = r_tail + PW'(w_wr_en);
        w_count_next = r_count + CW'(w_wr_en) - w_take_mem;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
    end
  end

  assign o_count = r_count;

  inst_queue_ram #(
    .DEPTH     (DEPTH),
    .EW        (EW),
    .DEQ_WIDTH (DEQ_WIDTH),
    .PW        (PW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr_en),
    .i_waddr (r_tail),
    .i_wdata (i_enq_entry),
    .i_head  (r_head),
    .o_rdata (w_ram_rdata)
  );

`ifndef SYNTHESIS
  a_take_legal: assert property (@(posedge i_clk) disable iff (i_rst)
    !i_rdy || (CW'(i_deq_take) <= w_avail));
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue at default parameters.
module tb_inst_fetch_queue;
  import cpu_defs::*;

  localparam int unsigned EW = INST_Q_ENTRY_WIDTH;

  logic          clk = 1'b0;
  logic          rst, rdy, flush, enq_valid, enq_ready;
  logic [EW-1:0] enq_entry;
  logic [1:0]    deq_valid, deq_take;
  logic [2*EW-1:0] deq_entry;
  logic [4:0]    count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_fetch_queue dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rdy       (rdy),
    .i_flush     (flush),
    .i_enq_valid (enq_valid),
    .i_enq_entry (enq_entry),
    .o_enq_ready (enq_ready),
    .o_deq_valid (deq_valid),
    .o_deq_entry (deq_entry),
    .i_deq_take  (deq_take),
    .o_count     (count)
  );

  function automatic logic [EW-1:0] mk(input logic [16:0] pc);
    inst_q_entry_t e;
    e.pc   = pc;
    e.inst = 32'h1300_0000 | {15'b0, pc};
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_entry = '0; deq_take = 2'd0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
    checks++; if (deq_valid !== 2'b00) begin failures++; $display("FAIL reset_deq_valid got=%b exp=00", deq_valid); end
  endtask

  task automatic test_basic();
    enq_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      enq_entry = mk(17'(4 * k));
      cycle();
    end
    enq_valid = 1'b0;
    #1;
    checks++; if (count !== 5'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", count); end
    checks++; if (deq_valid !== 2'b11) begin failures++; $display("FAIL basic_valid got=%b exp=11", deq_valid); end
    checks++; if (deq_entry[0 +: EW] !== mk(17'h0)) begin failures++; $display("FAIL basic_lane0 got=%h exp=%h", deq_entry[0 +: EW], mk(17'h0)); end
    checks++; if (deq_entry[EW +: EW] !== mk(17'h4)) begin failures++; $display("FAIL basic_lane1 got=%h exp=%h", deq_entry[EW +: EW], mk(17'h4)); end
    deq_take = 2'd2;
    cycle();
    deq_take = 2'd0;
    #1;
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL basic_count_after got=%0d exp=1", count); end
    checks++; if (deq_valid !== 2'b01) begin failures++; $display("FAIL basic_valid_after got=%b exp=01", deq_valid); end
    checks++; if (deq_entry[0 +: EW] !== mk(17'h8)) begin failures++; $display("FAIL basic_lane0_after got=%h exp=%h", deq_entry[0 +: EW], mk(17'h8)); end
    deq_take = 2'd1;
    cycle();
    deq_take = 2'd0;
  endtask

  task automatic test_full();
    logic [16:0] exp_pc;
    enq_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      enq_entry = mk(17'h100 + 17'(4 * k));
      cycle();
    end
    enq_entry = mk(17'h200);
    deq_take = 2'd1;
    #1;
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", count); end
    checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL full_enq_ready got=%b exp=0", enq_ready); end
    checks++; if (deq_valid !== 2'b11) begin failures++; $display("FAIL full_valid got=%b exp=11", deq_valid); end
    checks++; if (deq_entry[0 +: EW] !== mk(17'h100)) begin failures++; $display("FAIL full_lane0 got=%h exp=%h", deq_entry[0 +: EW], mk(17'h100)); end
    cycle();
    deq_take = 2'd0;
    #1;
    checks++; if (count !== 5'd15) begin failures++; $display("FAIL full_count_15 got=%0d exp=15", count); end
    checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL full_enq_ready_15 got=%b exp=1", enq_ready); end
    cycle();
    enq_valid = 1'b0;
    #1;
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL full_count_refill got=%0d exp=16", count); end
    for (int j = 0; j < 8; j++) begin
      deq_take = 2'd2;
      #1;
      for (int l = 0; l < 2; l++) begin
        exp_pc = (2 * j + l < 15) ? 17'h104 + 17'(4 * (2 * j + l)) : 17'h200;
        checks++;
        if (deq_entry[l*EW +: EW] !== mk(exp_pc)) begin
          failures++;
          $display("FAIL full_drain_%0d_lane%0d got=%h exp=%h", j, l, deq_entry[l*EW +: EW], mk(exp_pc));
        end
      end
      cycle();
    end
    deq_take = 2'd0;
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL full_drained got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    do_reset();
    enq_valid = 1'b1;
    enq_entry = mk(17'h300);
    cycle();
    for (int j = 1; j < 16; j++) begin
      enq_entry = mk(17'h300 + 17'(4 * j));
      deq_take = 2'd1;
      #1;
      checks++;
      if (deq_entry[0 +: EW] !== mk(17'h300 + 17'(4 * (j - 1))) || count !== 5'd1) begin
        failures++;
        $display("FAIL wrap_step_%0d got=%h/%0d exp=%h/1", j, deq_entry[0 +: EW], count, mk(17'h300 + 17'(4 * (j - 1))));
      end
      cycle();
    end
    enq_entry = mk(17'h340);
    deq_take = 2'd0;
    cycle();
    enq_valid = 1'b0;
    #1;
    checks++; if (count !== 5'd2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", count); end
    checks++; if (deq_entry[0 +: EW] !== mk(17'h33C)) begin failures++; $display("FAIL wrap_lane0 got=%h exp=%h", deq_entry[0 +: EW], mk(17'h33C)); end
    checks++; if (deq_entry[EW +: EW] !== mk(17'h340)) begin failures++; $display("FAIL wrap_lane1 got=%h exp=%h", deq_entry[EW +: EW], mk(17'h340)); end
    deq_take = 2'd2;
    cycle();
    deq_take = 2'd0;
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL wrap_drained got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    do_reset();
    enq_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      enq_entry = mk(17'h500 + 17'(4 * k));
      cycle();
    end
    enq_entry = mk(17'h5FC);
    deq_take = 2'd1;
    flush = 1'b1;
    #1;
    checks++; if (count !== 5'd5) begin failures++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
    cycle();
    flush = 1'b0; enq_valid = 1'b0; deq_take = 2'd0;
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (deq_valid !== 2'b00) begin failures++; $display("FAIL flush_valid got=%b exp=00", deq_valid); end
    checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL flush_enq_ready got=%b exp=1", enq_ready); end
    enq_valid = 1'b1;
    enq_entry = mk(17'h600);
    cycle();
    enq_valid = 1'b0;
    #1;
    checks++; if (deq_valid !== 2'b01) begin failures++; $display("FAIL flush_after_valid got=%b exp=01", deq_valid); end
    checks++; if (deq_entry[0 +: EW] !== mk(17'h600)) begin failures++; $display("FAIL flush_after_lane0 got=%h exp=%h", deq_entry[0 +: EW], mk(17'h600)); end
  endtask

  task automatic test_freeze();
    enq_valid = 1'b1;
    for (int k = 1; k < 3; k++) begin
      enq_entry = mk(17'h600 + 17'(4 * k));
      cycle();
    end
    rdy = 1'b0;
    enq_entry = mk(17'h6FC);
    deq_take = 2'd2;
    for (int c = 0; c < 3; c++) begin
      flush = (c == 1);
      #1;
      checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL freeze_enq_ready_%0d got=%b exp=0", c, enq_ready); end
      checks++; if (deq_valid !== 2'b00) begin failures++; $display("FAIL freeze_valid_%0d got=%b exp=00", c, deq_valid); end
      cycle();
    end
    rdy = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_take = 2'd0;
    #1;
    checks++; if (count !== 5'd3) begin failures++; $display("FAIL freeze_count got=%0d exp=3", count); end
    checks++; if (deq_entry[0 +: EW] !== mk(17'h600)) begin failures++; $display("FAIL freeze_lane0 got=%h exp=%h", deq_entry[0 +: EW], mk(17'h600)); end
    checks++; if (deq_entry[EW +: EW] !== mk(17'h604)) begin failures++; $display("FAIL freeze_lane1 got=%h exp=%h", deq_entry[EW +: EW], mk(17'h604)); end
    deq_take = 2'd2;
    cycle();
    deq_take = 2'd0;
    #1;
    checks++; if (deq_entry[0 +: EW] !== mk(17'h608) || count !== 5'd1) begin failures++; $display("FAIL freeze_tail got=%h/%0d exp=%h/1", deq_entry[0 +: EW], count, mk(17'h608)); end
    deq_take = 2'd1;
    cycle();
    deq_take = 2'd0;
  endtask

  task automatic test_bypass();
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL bypass_pre_count got=%0d exp=0", count); end
    enq_valid = 1'b1;
    enq_entry = mk(17'h40);
`ifdef INST_QUEUE_BYPASS_EN
    deq_take = 2'd1;
    #1;
    checks++; if (deq_valid !== 2'b01) begin failures++; $display("FAIL bypass_valid got=%b exp=01", deq_valid); end
    checks++; if (deq_entry[0 +: EW] !== mk(17'h40)) begin failures++; $display("FAIL bypass_lane0 got=%h exp=%h", deq_entry[0 +: EW], mk(17'h40)); end
    cycle();
    enq_valid = 1'b0; deq_take = 2'd0;
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL bypass_count got=%0d exp=0", count); end
    checks++; if (deq_valid !== 2'b00) begin failures++; $display("FAIL bypass_after_valid got=%b exp=00", deq_valid); end
`else
    deq_take = 2'd0;
    #1;
    checks++; if (deq_valid !== 2'b00) begin failures++; $display("FAIL nobypass_valid got=%b exp=00", deq_valid); end
    cycle();
    enq_valid = 1'b0;
    #1;
    checks++; if (deq_valid !== 2'b01) begin failures++; $display("FAIL nobypass_next_valid got=%b exp=01", deq_valid); end
    checks++; if (deq_entry[0 +: EW] !== mk(17'h40)) begin failures++; $display("FAIL nobypass_lane0 got=%h exp=%h", deq_entry[0 +: EW], mk(17'h40)); end
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL nobypass_count got=%0d exp=1", count); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_flush();
    test_freeze();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
